id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage RV64 pipeline.
- Latches decoded control signals from the ID-stage control unit, plus operands, immediate, PC and register indices.
- Contains the load-use hazard detector: it inserts a bubble into EX and tells IF/ID to hold.
- Handles branch-flush squash and an external back-pressure hold. Provides a saturating load-use stall counter for performance monitoring.

Parameters:
XLEN, 64, datapath width (operands, immediate, PC)
CNT_W, 32, width of stall counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  generated immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_mem_read, id_mem_write, id_reg_write, id_branch, id_alu_src_b_sel  in  1  control unit outputs
id_alu_funct3  in  3  control unit output
id_alu_funct7  in  7  control unit output
hold_i  in  1  downstream stall; freeze EX register
flush_i  in  1  branch taken resolved in EX; squash ID instruction
load_use_stall_o  out  1  combinational; PC and IF/ID must hold this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  out  5  registered copies
ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_alu_src_b_sel  out  1  registered control
ex_alu_funct3  out  3  registered control
ex_alu_funct7  out  7  registered control
stall_count  out  CNT_W  number of bubbles inserted by load-use hazards

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output is 0, ex_valid=0, stall_count=0. A reset mid-operation discards the EX contents immediately.
- load_use_stall_o is 1 only when all of the following hold:
  - id_valid and ex_valid and ex_mem_read;
  - ex_rd != 0;
  - (ex_rd==id_rs1) or (ex_rd==id_rs2 and uses_rs2);
  - flush_i=0 and hold_i=0.
- uses_rs2 = !id_alu_src_b_sel | id_mem_write | id_branch. rs1 is treated as always used.
- Register update at posedge, priority highest first:
  1. hold_i=1: all EX outputs keep their value; counter unchanged; flush_i ignored (the source keeps it asserted until hold drops).
  2. flush_i=1: bubble.
  3. load_use_stall_o=1: bubble; stall_count increments.
  4. Otherwise: load all id_* into ex_*; ex_valid=id_valid.
- Bubble definition:
  - ex_valid=0, ex_mem_read=0, ex_mem_write=0, ex_reg_write=0, ex_branch=0.
  - Datapath fields (pc, data, imm, indices, funct, alu_src_b_sel) may be don't-care; implementation zeroes them.
- If id_valid=0, control bits are loaded as 0 regardless of id_* control inputs. An invalid instruction never writes or branches.
- Latency: one cycle ID to EX.
- A load-use stall lasts exactly one cycle per hazard. The following cycle EX holds a bubble, so the hazard condition clears.
- stall_count saturates at all-ones and does not wrap.
- No combinational path exists from hold_i or flush_i to ex_* outputs. load_use_stall_o is combinational from ex_* registers and id_* inputs.

Test Plan:
- Reset: drive rst_n low mid-cycle with EX holding valid ld -> all outputs 0 immediately, stall_count=0.
- Load-use: EX = ld x5 (mem_read=1, rd=5); ID = add x6,x5,x7 -> load_use_stall_o=1; next cycle ex_valid=0, ex_reg_write=0, stall_count=1; following cycle add enters EX with ex_rd=6.
- No false hazard:
  - EX ld x0, ID add x1,x0,x0 -> no stall.
  - EX ld x5, ID addi x6,x7,4 with id_rs2=5 (alu_src_b_sel=1) -> no stall.
  - EX ld x5, ID sd x5 (rs2=5) -> stall.
- Flush: flush_i=1 with ID beq valid -> next cycle ex_valid=0, ex_branch=0; simultaneous load-use condition -> load_use_stall_o=0, counter unchanged.
- Hold: hold_i=1 for 3 cycles while ID inputs change -> ex_* unchanged, load_use_stall_o=0; release -> ID values loaded next edge.
- Saturation: preload via CNT_W=2, force 5 consecutive hazards -> stall_count stops at 3.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage boundary: decoded ID fields in, registered EX fields out,
// plus the stall/flush controls and the load-use perf counter.
interface id_ex_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_mem_read, id_mem_write, id_reg_write, id_branch, id_alu_src_b_sel;
  logic [2:0]      id_alu_funct3;
  logic [6:0]      id_alu_funct7;
  logic            hold_i, flush_i;
  logic            load_use_stall_o;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_alu_src_b_sel;
  logic [2:0]      ex_alu_funct3;
  logic [6:0]      ex_alu_funct7;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_mem_read, id_mem_write, id_reg_write, id_branch, id_alu_src_b_sel,
           id_alu_funct3, id_alu_funct7, hold_i, flush_i,
    input  load_use_stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch,
           ex_alu_src_b_sel, ex_alu_funct3, ex_alu_funct7, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_mem_read, id_mem_write, id_reg_write, id_branch, id_alu_src_b_sel,
           id_alu_funct3, id_alu_funct7, hold_i, flush_i,
    output load_use_stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch,
           ex_alu_src_b_sel, ex_alu_funct3, ex_alu_funct7, stall_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch squash,
// downstream hold and a saturating load-use bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic            mem_read, mem_write, reg_write, branch, alu_src_b_sel;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
  } ex_t;

  ex_t              ex_q, id_d;
  logic [CNT_W-1:0] cnt_q;
  logic             uses_rs2, hazard;

  // rs1 is conservatively treated as always read; rs2 only when it feeds ALU/store/branch
  assign uses_rs2 = !bus.id_alu_src_b_sel | bus.id_mem_write | bus.id_branch;
  assign hazard   = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == bus.id_rs1) | ((ex_q.rd == bus.id_rs2) & uses_rs2)) &
                    !bus.flush_i & !bus.hold_i;
  assign bus.load_use_stall_o = hazard;

  // an invalid ID slot must never write, access memory or branch
  always_comb begin
    id_d               = '0;
    id_d.valid         = bus.id_valid;
    id_d.pc            = bus.id_pc;
    id_d.rs1_data      = bus.id_rs1_data;
    id_d.rs2_data      = bus.id_rs2_data;
    id_d.imm           = bus.id_imm;
    id_d.rs1           = bus.id_rs1;
    id_d.rs2           = bus.id_rs2;
    id_d.rd            = bus.id_rd;
    id_d.mem_read      = bus.id_valid & bus.id_mem_read;
    id_d.mem_write     = bus.id_valid & bus.id_mem_write;
    id_d.reg_write     = bus.id_valid & bus.id_reg_write;
    id_d.branch        = bus.id_valid & bus.id_branch;
    id_d.alu_src_b_sel = bus.id_alu_src_b_sel;
    id_d.funct3        = bus.id_alu_funct3;
    id_d.funct7        = bus.id_alu_funct7;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bus.hold_i) begin
      ex_q  <= ex_q;
    end else if (bus.flush_i) begin
      ex_q  <= '0;
    end else if (hazard) begin
      ex_q  <= '0;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else begin
      ex_q  <= id_d;
    end
  end

  assign bus.ex_valid         = ex_q.valid;
  assign bus.ex_pc            = ex_q.pc;
  assign bus.ex_rs1_data      = ex_q.rs1_data;
  assign bus.ex_rs2_data      = ex_q.rs2_data;
  assign bus.ex_imm           = ex_q.imm;
  assign bus.ex_rs1           = ex_q.rs1;
  assign bus.ex_rs2           = ex_q.rs2;
  assign bus.ex_rd            = ex_q.rd;
  assign bus.ex_mem_read      = ex_q.mem_read;
  assign bus.ex_mem_write     = ex_q.mem_write;
  assign bus.ex_reg_write     = ex_q.reg_write;
  assign bus.ex_branch        = ex_q.branch;
  assign bus.ex_alu_src_b_sel = ex_q.alu_src_b_sel;
  assign bus.ex_alu_funct3    = ex_q.funct3;
  assign bus.ex_alu_funct7    = ex_q.funct7;
  assign bus.stall_count      = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg; narrow counter so saturation is reachable.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(64), .CNT_W(2)) bus();
  id_ex_stage_reg #(.XLEN(64), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        v, mr, mw, rw, br;
    logic [63:0] pc, a;
    logic [4:0]  rd;
    logic [1:0]  cnt;
  } st_t;

  st_t m, e;
  st_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic set_id(input logic v, input logic [4:0] rs1, rs2, rd,
                        input logic mr, mw, rw, br, asb, input logic [63:0] pc);
    bus.id_valid = v;  bus.id_pc = pc;
    bus.id_rs1_data = pc + 64'h100;  bus.id_rs2_data = pc + 64'h200;
    bus.id_imm = ~pc;
    bus.id_rs1 = rs1;  bus.id_rs2 = rs2;  bus.id_rd = rd;
    bus.id_mem_read = mr;  bus.id_mem_write = mw;  bus.id_reg_write = rw;
    bus.id_branch = br;  bus.id_alu_src_b_sel = asb;
    bus.id_alu_funct3 = pc[2:0];  bus.id_alu_funct7 = pc[9:3];
  endtask

  function automatic logic model_haz();
    return bus.id_valid && m.v && m.mr && (m.rd != 5'd0) &&
           ((m.rd == bus.id_rs1) ||
            ((m.rd == bus.id_rs2) && (!bus.id_alu_src_b_sel || bus.id_mem_write || bus.id_branch))) &&
           !bus.flush_i && !bus.hold_i;
  endfunction

  // advance one clock: predict the EX state, queue it, let the checker compare
  task automatic step();
    st_t n;
    logic h;
    h = model_haz();
    n = m;
    if (bus.hold_i) n = m;
    else if (bus.flush_i || h) begin
      n = '{default: '0};
      n.cnt = (h && m.cnt != 2'd3) ? m.cnt + 2'd1 : m.cnt;
    end else begin
      n.v  = bus.id_valid;
      n.mr = bus.id_valid & bus.id_mem_read;
      n.mw = bus.id_valid & bus.id_mem_write;
      n.rw = bus.id_valid & bus.id_reg_write;
      n.br = bus.id_valid & bus.id_branch;
      n.pc = bus.id_pc;  n.a = bus.id_rs1_data;  n.rd = bus.id_rd;
      n.cnt = m.cnt;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if ({bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch,
           bus.ex_pc, bus.ex_rs1_data, bus.ex_rd} !== {e.v, e.mr, e.mw, e.rw, e.br, e.pc, e.a, e.rd}) begin
        bad++;
        $display("FAIL sb_ex got v=%b mr=%b mw=%b rw=%b br=%b pc=%h a=%h rd=%0d want v=%b mr=%b mw=%b rw=%b br=%b pc=%h a=%h rd=%0d",
                 bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch,
                 bus.ex_pc, bus.ex_rs1_data, bus.ex_rd, e.v, e.mr, e.mw, e.rw, e.br, e.pc, e.a, e.rd);
      end
      total++;
      if (bus.stall_count !== e.cnt) begin
        bad++;
        $display("FAIL sb_cnt got=%0d want=%0d", bus.stall_count, e.cnt);
      end
    end
  end

  task automatic test_reset();
    bus.hold_i = 0;  bus.flush_i = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
    #12;
    total++;
    if ({bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.stall_count} !== '0) begin
      bad++; $display("FAIL reset_state got v=%b pc=%h rd=%0d cnt=%0d want all 0",
                      bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.stall_count);
    end
    @(negedge clk) rst_n = 1;
    m = '{default: '0};
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h1000);
    step();
    rst_n = 0;
    #1;
    total++;
    if ({bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write, bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.stall_count} !== '0) begin
      bad++; $display("FAIL async_reset got v=%b mr=%b pc=%h rd=%0d want all 0",
                      bus.ex_valid, bus.ex_mem_read, bus.ex_pc, bus.ex_rd);
    end
    m = '{default: '0};
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h2000);   // ld x5
    step();
    set_id(1, 5, 7, 6, 0, 0, 1, 0, 0, 64'h2004);   // add x6,x5,x7
    #1;
    total++;
    if (bus.load_use_stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", bus.load_use_stall_o); end
    step();
    total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.stall_count} !== {1'b0, 1'b0, 2'd1}) begin
      bad++; $display("FAIL lu_bubble got v=%b rw=%b cnt=%0d want v=0 rw=0 cnt=1",
                      bus.ex_valid, bus.ex_reg_write, bus.stall_count);
    end
    total++;
    if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL lu_clear got=%b want=0", bus.load_use_stall_o); end
    step();
    total++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_pc} !== {1'b1, 5'd6, 64'h2004}) begin
      bad++; $display("FAIL lu_enter got v=%b rd=%0d pc=%h want v=1 rd=6 pc=2004", bus.ex_valid, bus.ex_rd, bus.ex_pc);
    end
  endtask

  task automatic test_no_false();
    set_id(1, 1, 0, 0, 1, 0, 1, 0, 1, 64'h3000);   // ld x0
    step();
    set_id(1, 0, 0, 1, 0, 0, 1, 0, 0, 64'h3004);   // add x1,x0,x0
    #1; total++;
    if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL nf_x0 got=%b want=0", bus.load_use_stall_o); end
    step();
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h3008);   // ld x5
    step();
    set_id(1, 7, 5, 6, 0, 0, 1, 0, 1, 64'h300c);   // addi x6,x7,4 with stray rs2=5
    #1; total++;
    if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL nf_imm got=%b want=0", bus.load_use_stall_o); end
    step();
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h3010);   // ld x5
    step();
    set_id(0, 5, 5, 6, 1, 1, 1, 1, 0, 64'h3014);   // invalid slot aimed at x5
    #1; total++;
    if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL nf_invalid got=%b want=0", bus.load_use_stall_o); end
    set_id(1, 2, 5, 0, 0, 1, 0, 0, 1, 64'h3018);   // sd x5,0(x2)
    #1; total++;
    if (bus.load_use_stall_o !== 1'b1) begin bad++; $display("FAIL nf_sd got=%b want=1", bus.load_use_stall_o); end
    step();
    step();
    set_id(0, 0, 0, 3, 1, 1, 1, 1, 0, 64'h301c);   // invalid with all control asserted
    step();
    total++;
    if ({bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch} !== 4'b0) begin
      bad++; $display("FAIL invalid_ctl got=%b want=0000",
                      {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch});
    end
  endtask

  task automatic test_flush();
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h4000);   // ld x5
    step();
    set_id(1, 5, 6, 0, 0, 0, 0, 1, 0, 64'h4004);   // beq x5,x6
    bus.flush_i = 1;
    #1; total++;
    if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b want=0", bus.load_use_stall_o); end
    step();
    bus.flush_i = 0;
    total++;
    if ({bus.ex_valid, bus.ex_branch, bus.stall_count} !== {1'b0, 1'b0, 2'd2}) begin
      bad++; $display("FAIL fl_bubble got v=%b br=%b cnt=%0d want v=0 br=0 cnt=2",
                      bus.ex_valid, bus.ex_branch, bus.stall_count);
    end
  endtask

  task automatic test_hold();
    set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h5000);   // ld x5
    step();
    bus.hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5, 5, 5'(6 + i), 0, 0, 1, 0, 0, 64'h5100 + 64'(i * 4));
      bus.flush_i = (i == 1);
      #1; total++;
      if (bus.load_use_stall_o !== 1'b0) begin bad++; $display("FAIL hold_stall got=%b want=0", bus.load_use_stall_o); end
      step();
      total++;
      if ({bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.ex_pc} !== {1'b1, 1'b1, 5'd5, 64'h5000}) begin
        bad++; $display("FAIL hold_keep got v=%b mr=%b rd=%0d pc=%h want v=1 mr=1 rd=5 pc=5000",
                        bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.ex_pc);
      end
    end
    bus.hold_i = 0;  bus.flush_i = 0;
    set_id(1, 9, 10, 11, 0, 0, 1, 0, 0, 64'h5200);
    step();
    total++;
    if ({bus.ex_rd, bus.ex_pc, bus.ex_rs2_data} !== {5'd11, 64'h5200, 64'h5400}) begin
      bad++; $display("FAIL hold_release got rd=%0d pc=%h b=%h want rd=11 pc=5200 b=5400",
                      bus.ex_rd, bus.ex_pc, bus.ex_rs2_data);
    end
  endtask

  task automatic test_saturation();
    rst_n = 0;  #1;
    m = '{default: '0};
    @(negedge clk) rst_n = 1;
    for (int k = 1; k <= 5; k++) begin
      set_id(1, 1, 0, 5, 1, 0, 1, 0, 1, 64'h6000 + 64'(k * 8));
      step();
      set_id(1, 5, 2, 6, 0, 0, 1, 0, 0, 64'h6004 + 64'(k * 8));
      step();
      total++;
      if (bus.stall_count !== ((k > 3) ? 2'd3 : 2'(k))) begin
        bad++; $display("FAIL sat_k%0d got=%0d want=%0d", k, bus.stall_count, (k > 3) ? 3 : k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false();
    test_flush();
    test_hold();
    test_saturation();
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
